// File: rtl/color_sensor_meter_pkg.sv
// Shared codes and FSM types for the colour-frequency sensor front end.
package color_pkg;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  localparam logic [2:0] COL_NONE  = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b001;
  localparam logic [2:0] COL_BLUE  = 3'b010;
  localparam logic [2:0] COL_GREEN = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_LATCH,
    ST_CLASSIFY
  } state_e;

  typedef enum logic [1:0] {
    CH_R,
    CH_B,
    CH_G
  } ch_e;

endpackage

// File: rtl/color_sensor_meter_edge_sync_counter.sv
// Synchronises an asynchronous square wave into clk and counts its rising
// edges in a saturating accumulator while count_en_i is high.
module edge_sync_counter #(
  parameter int COUNT_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_i,
  input  logic               clear_i,
  input  logic               count_en_i,
  output logic [COUNT_W-1:0] count_o
);

  logic               sync1_q, sync2_q, sync3_q;
  logic               rise;
  logic [COUNT_W-1:0] acc_q, acc_d;

  assign rise = sync2_q & ~sync3_q;

  // Clear has priority so a new window always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (count_en_i && rise && (acc_q != '1)) begin
      acc_d = acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      acc_q   <= acc_d;
    end
  end

  assign count_o = acc_q;

endmodule

// File: rtl/color_sensor_meter.sv
// TCS3200-style colour meter: steps the filter R->B->G, counts sensor edges
// over a gate window per channel, then publishes counts and dominant colour.
module color_sensor_meter
  import color_pkg::*;
#(
  parameter int         GATE_CYCLES   = 100000,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         COUNT_W       = 20,
  parameter int         MIN_COUNT     = 16,
  parameter int         MARGIN        = 4,
  parameter logic [1:0] SCALE         = 2'b11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sensor_freq,
  output logic [1:0]         scale,
  output logic [1:0]         filter,
  output logic [COUNT_W-1:0] red_count,
  output logic [COUNT_W-1:0] blue_count,
  output logic [COUNT_W-1:0] green_count,
  output logic [2:0]         color,
  output logic               valid
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef logic [TW-1:0]    tmr_t;
  typedef logic [COUNT_W:0] ext_t;

  localparam tmr_t GATE_LAST   = tmr_t'(GATE_CYCLES - 1);
  localparam tmr_t SETTLE_LAST = tmr_t'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam ext_t MIN_E       = ext_t'(MIN_COUNT);
  localparam ext_t MARGIN_E    = ext_t'(MARGIN);

  state_e             state_q;
  ch_e                ch_q;
  tmr_t               timer_q;
  logic [1:0]         filter_q;
  logic [COUNT_W-1:0] red_sh_q, blue_sh_q;
  logic [COUNT_W-1:0] red_q, blue_q, green_q;
  logic [2:0]         color_q;
  logic               valid_q;
  logic [COUNT_W-1:0] acc;

  // Widened by one bit so Y+MARGIN never wraps.
  function automatic logic [2:0] classify(input logic [COUNT_W-1:0] r,
                                          input logic [COUNT_W-1:0] b,
                                          input logic [COUNT_W-1:0] g);
    ext_t       re, be, ge;
    logic [2:0] res;
    re  = {1'b0, r};
    be  = {1'b0, b};
    ge  = {1'b0, g};
    res = COL_NONE;
    if (re >= MIN_E && re > be + MARGIN_E && re > ge + MARGIN_E) res = COL_RED;
    if (be >= MIN_E && be > re + MARGIN_E && be > ge + MARGIN_E) res = COL_BLUE;
    if (ge >= MIN_E && ge > re + MARGIN_E && ge > be + MARGIN_E) res = COL_GREEN;
    return res;
  endfunction

  edge_sync_counter #(
    .COUNT_W (COUNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_i      (sensor_freq),
    .clear_i    (state_q == ST_SETTLE),
    .count_en_i (state_q == ST_GATE),
    .count_o    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_R;
      timer_q   <= '0;
      filter_q  <= FILT_RED;
      red_sh_q  <= '0;
      blue_sh_q <= '0;
      red_q     <= '0;
      blue_q    <= '0;
      green_q   <= '0;
      color_q   <= COL_NONE;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          filter_q <= FILT_RED;
          if (enable) begin
            state_q <= ST_SETTLE;
            ch_q    <= CH_R;
            timer_q <= '0;
          end
        end
        ST_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_q <= '0;
            state_q <= ST_GATE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_GATE: begin
          if (timer_q == GATE_LAST) begin
            timer_q <= '0;
            state_q <= ST_LATCH;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_LATCH: begin
          case (ch_q)
            CH_R: begin
              red_sh_q <= acc;
              ch_q     <= CH_B;
              filter_q <= FILT_BLUE;
              state_q  <= ST_SETTLE;
            end
            CH_B: begin
              blue_sh_q <= acc;
              ch_q      <= CH_G;
              filter_q  <= FILT_GREEN;
              state_q   <= ST_SETTLE;
            end
            default: begin
              // Green is consumed straight from the accumulator, which holds
              // until the next SETTLE, so results are visible during CLASSIFY.
              red_q   <= red_sh_q;
              blue_q  <= blue_sh_q;
              green_q <= acc;
              color_q <= classify(red_sh_q, blue_sh_q, acc);
              valid_q <= 1'b1;
              state_q <= ST_CLASSIFY;
            end
          endcase
        end
        ST_CLASSIFY: begin
          filter_q <= FILT_RED;
          ch_q     <= CH_R;
          timer_q  <= '0;
          state_q  <= enable ? ST_SETTLE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign scale       = SCALE;
  assign filter      = filter_q;
  assign red_count   = red_q;
  assign blue_count  = blue_q;
  assign green_count = green_q;
  assign color       = color_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_color_sensor_meter.sv
// Directed bench for color_sensor_meter: periodic and burst sensor stimulus
// keyed to the filter code, plus a small-width instance for saturation.
module tb_color_sensor_meter;

  logic        clk;
  logic        rst_n, enable, sensor_freq;
  logic [1:0]  scale, filter;
  logic [19:0] red_count, blue_count, green_count;
  logic [2:0]  color;
  logic        valid;

  logic        en_sat, sens_sat;
  logic [1:0]  scale_sat, filter_sat;
  logic [3:0]  red_sat, blue_sat, green_sat;
  logic [2:0]  color_sat;
  logic        valid_sat;

  int          n_vec = 0;
  int          n_err = 0;
  int          per[4];
  int          burst[4];
  bit          burst_mode;
  int          kick_cnt;
  logic [1:0]  fseq[$];
  int          lat;

  color_sensor_meter #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(20),
    .MIN_COUNT(16), .MARGIN(4), .SCALE(2'b11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_freq(sensor_freq),
    .scale(scale), .filter(filter), .red_count(red_count),
    .blue_count(blue_count), .green_count(green_count),
    .color(color), .valid(valid)
  );

  color_sensor_meter #(
    .GATE_CYCLES(200), .SETTLE_CYCLES(4), .COUNT_W(4),
    .MIN_COUNT(16), .MARGIN(4), .SCALE(2'b11)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en_sat), .sensor_freq(sens_sat),
    .scale(scale_sat), .filter(filter_sat), .red_count(red_sat),
    .blue_count(blue_sat), .green_count(green_sat),
    .color(color_sat), .valid(valid_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Collapses a count within +-1 of the nominal onto the nominal.
  function automatic int tol(input int v, input int e);
    return (v >= e - 1 && v <= e + 1) ? e : v;
  endfunction

  // Main sensor: periodic per filter code, or a fixed pulse burst per channel.
  initial begin : gen
    logic [1:0] last_f;
    int         seen_kick, ph, left, dly, p;
    sensor_freq = 1'b0;
    last_f = 2'b00; seen_kick = 0; ph = 0; left = 0; dly = 0;
    forever begin
      @(posedge clk); #2;
      if (filter !== last_f || seen_kick != kick_cnt) begin
        last_f = filter; seen_kick = kick_cnt;
        ph = 0; left = burst[filter]; dly = 10; sensor_freq = 1'b0;
      end else if (burst_mode) begin
        if (dly > 0) dly--;
        else if (left > 0) begin
          if (!sensor_freq) sensor_freq = 1'b1;
          else begin sensor_freq = 1'b0; left--; end
        end
      end else begin
        p = per[filter];
        sensor_freq = (ph < p / 2);
        ph = (ph + 1 >= p) ? 0 : ph + 1;
      end
    end
  end

  initial begin : gen_sat
    int ph;
    sens_sat = 1'b0; ph = 0;
    forever begin
      @(posedge clk); #2;
      sens_sat = (ph < 2);
      ph = (ph + 1) % 4;
    end
  end

  task automatic run_round(input bit drop, output int l);
    int bcnt;
    bit got;
    l = 0; bcnt = 0; got = 0;
    fseq.delete();
    @(negedge clk);
    enable = 1'b1; kick_cnt++;
    fseq.push_back(filter);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); l++;
      @(negedge clk);
      if (filter !== fseq[$]) fseq.push_back(filter);
      if (drop && filter == 2'b01) begin
        bcnt++;
        if (bcnt == 4) enable = 1'b0;
      end
      if (valid) begin got = 1; break; end
    end
    if (!got) check("round_timeout", 0, 1);
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("valid_width", valid, 0);
  endtask

  task automatic set_per(input int r, input int b, input int g);
    per[0] = r; per[1] = b; per[3] = g; per[2] = 4;
  endtask

  task automatic set_burst(input int r, input int b, input int g);
    burst[0] = r; burst[1] = b; burst[3] = g; burst[2] = 0;
  endtask

  initial begin : main
    int nv, nf;
    bit got;
    enable = 1'b0; en_sat = 1'b0; burst_mode = 1'b0; kick_cnt = 0;
    set_per(4, 4, 4); set_burst(0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_color", color, 0);
    check("rst_red", red_count, 0);
    check("rst_blue", blue_count, 0);
    check("rst_green", green_count, 0);
    check("rst_filter", filter, 0);
    check("rst_valid", valid, 0);
    check("rst_scale", scale, 3);
    rst_n = 1'b1;

    // Red dominant, nominal 25/10/5.
    set_per(4, 10, 20);
    run_round(0, lat);
    check("a_latency", lat, 316);
    check("a_red", tol(red_count, 25), 25);
    check("a_blue", tol(blue_count, 10), 10);
    check("a_green", tol(green_count, 5), 5);
    check("a_color", color, 3'b001);

    // After the round with enable low: idle, silent, outputs held.
    nv = 0; nf = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid) nv++;
      if (filter != 2'b00) nf++;
    end
    check("idle_valid", nv, 0);
    check("idle_filter", nf, 0);
    check("hold_red", tol(red_count, 25), 25);
    check("hold_color", color, 3'b001);

    // Green dominant and filter sequence.
    set_per(10, 10, 4);
    run_round(0, lat);
    check("g_seq_len", fseq.size(), 3);
    if (fseq.size() == 3) begin
      check("g_seq0", fseq[0], 2'b00);
      check("g_seq1", fseq[1], 2'b01);
      check("g_seq2", fseq[2], 2'b11);
    end
    check("g_green", tol(green_count, 25), 25);
    check("g_color", color, 3'b100);

    set_per(4, 4, 4);
    run_round(0, lat);
    check("tie_color", color, 3'b000);

    set_per(10, 20, 20);
    run_round(0, lat);
    check("low_red", tol(red_count, 10), 10);
    check("low_color", color, 3'b000);

    // Exact counts via bursts: margin boundary, just above it, blue winner.
    burst_mode = 1'b1;
    set_burst(20, 16, 5);
    run_round(0, lat);
    check("m_red", red_count, 20);
    check("m_blue", blue_count, 16);
    check("m_green", green_count, 5);
    check("m_color", color, 3'b000);
    set_burst(21, 16, 5);
    run_round(0, lat);
    check("m1_color", color, 3'b001);
    set_burst(3, 30, 25);
    run_round(0, lat);
    check("b_blue", blue_count, 30);
    check("b_red", red_count, 3);
    check("b_color", color, 3'b010);
    burst_mode = 1'b0;

    // Enable dropped around the blue gate: round still publishes once.
    set_per(4, 10, 20);
    run_round(1, lat);
    check("drop_latency", lat, 316);
    check("drop_color", color, 3'b001);
    nv = 0; nf = 0;
    repeat (400) begin
      @(negedge clk);
      if (valid) nv++;
      if (filter != 2'b00) nf++;
    end
    check("drop_idle_valid", nv, 0);
    check("drop_idle_filter", nf, 0);
    run_round(0, lat);
    check("reen_latency", lat, 316);
    check("reen_seq0", fseq[0], 2'b00);
    check("reen_color", color, 3'b001);

    // Reset during the blue gate.
    @(negedge clk);
    enable = 1'b1; kick_cnt++;
    repeat (170) @(negedge clk);
    check("pre_rst_filter", filter, 2'b01);
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("mr_color", color, 0);
    check("mr_red", red_count, 0);
    check("mr_green", green_count, 0);
    check("mr_filter", filter, 0);
    check("mr_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_round(0, lat);
    check("mr_latency", lat, 316);
    check("mr_new_color", color, 3'b001);

    // Saturation on the 4-bit instance.
    @(negedge clk);
    en_sat = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (valid_sat) begin got = 1; break; end
    end
    en_sat = 1'b0;
    check("sat_got", got, 1);
    check("sat_latency", lat, 616);
    check("sat_red", red_sat, 15);
    check("sat_blue", blue_sat, 15);
    check("sat_green", green_sat, 15);
    check("sat_color", color_sat, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/color_sensor_meter.md
Name: color_sensor_meter

Overview:
- Parametrised successor to the single-channel colour-frequency front end for the TCS3200-style light-to-frequency sensor on the rover.
- Steps the sensor filter through red, blue and green. For each channel it counts output edges over a programmable gate window.
- Latches the three counts, classifies the dominant colour, and pulses a valid strobe.
- Counts sensor edges as synchronised clk-domain events; sensor_freq is never used as a clock.

Parameters:
- GATE_CYCLES, 100000, clk cycles per counting window (>=1).
- SETTLE_CYCLES, 1000, clk cycles discarded after each filter change (>=0).
- COUNT_W, 20, width of each channel count; counts saturate at all-ones.
- MIN_COUNT, 16, minimum dominant-channel count for a colour decision.
- MARGIN, 4, amount by which the dominant count must strictly exceed both other counts.
- SCALE, 2'b11, constant driven on scale (S0/S1 output-frequency scaling).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run continuous measurement rounds while high.
- sensor_freq  in  1  asynchronous sensor square wave.
- scale  out  2  sensor S0/S1, constant SCALE.
- filter  out  2  sensor S2/S3: 00 red, 01 blue, 11 green.
- red_count  out  COUNT_W  last latched red count.
- blue_count  out  COUNT_W  last latched blue count.
- green_count  out  COUNT_W  last latched green count.
- color  out  3  001 red, 010 blue, 100 green, 000 undecided.
- valid  out  1  one-cycle pulse when a round's results update.

Behaviour:
- Reset (async assert, sync release): state IDLE, filter 00, color 000, all counts 0, valid 0, synchroniser flops 0. scale = SCALE at all times.
- Input path: 2-flop synchroniser on sensor_freq, plus a third flop for edge detect. A rising edge is sync2 & ~sync3. Edge-detect latency is 2-3 clk.
- FSM states: IDLE, SETTLE, GATE, LATCH, CLASSIFY. The channel index ch steps R -> B -> G.
- IDLE:
  - filter = 00.
  - When enable=1: next state SETTLE, ch=R, timer cleared.
- SETTLE:
  - Runs SETTLE_CYCLES cycles; then GATE, with the edge accumulator cleared.
  - If SETTLE_CYCLES=0, SETTLE lasts exactly 1 cycle.
- GATE:
  - Runs exactly GATE_CYCLES cycles.
  - Each detected edge in those cycles increments the accumulator, saturating at 2^COUNT_W-1.
  - Edges in any other state are ignored.
- LATCH (1 cycle):
  - Accumulator is written to the channel's shadow register.
  - If ch is R or B: advance ch, drive the new filter code, go to SETTLE.
  - If ch is G: go to CLASSIFY.
- filter always equals the code of the current ch and changes at LATCH exit.
- CLASSIFY (1 cycle):
  - Shadow registers are copied to red/blue/green_count.
  - color is computed from the shadow values and registered.
  - valid=1 for this cycle only.
  - Next state is SETTLE with ch=R if enable=1, else IDLE.
- Classification rule (shadow values):
  - Channel X wins if X >= MIN_COUNT and X > Y+MARGIN for both other channels Y.
  - Comparisons use COUNT_W+1-bit arithmetic, so no overflow.
  - No winner (including ties) gives color 000.
- Round latency from IDLE exit to valid: 3*(max(SETTLE_CYCLES,1)+GATE_CYCLES+1)+1 cycles.
- enable deasserted mid-round: the round finishes and publishes; the FSM then returns to IDLE. Outputs hold their last values.
- Reset mid-round: all state is discarded, no valid pulse, outputs return to reset values.
- Simultaneous edge and GATE exit: an edge detected on the final GATE cycle is counted. An edge detected in LATCH is not.
- Timers use $clog2 of the larger of GATE_CYCLES and SETTLE_CYCLES, plus 1 bit.

Decomposition:
- Shared package color_pkg holds:
  - filter codes FILT_RED=2'b00, FILT_BLUE=2'b01, FILT_GREEN=2'b11, FILT_CLEAR=2'b10;
  - colour codes COL_NONE/RED/BLUE/GREEN;
  - the FSM state enum.
- Sub-module edge_sync_counter: synchroniser, edge detect, and the saturating COUNT_W accumulator with clear and count_en inputs. It is reused for future clear-channel and ambient measurement.

Test Plan:
- Reset mid-GATE: assert rst_n=0 during GATE -> color=000, counts=0, filter=00, valid=0 immediately, with no valid pulse after release until a full round completes.
- GATE_CYCLES=100, SETTLE_CYCLES=4, sensor period 4 clk on red, 10 on blue, 20 on green -> red_count 25±1, blue 10±1, green 5±1, color=001, valid a single-cycle pulse at the computed latency.
- Green dominant, period 4 on green vs 10 elsewhere -> color=100. filter sequence observed as 00, 01, 11.
- Ties/low light:
  - equal periods on all channels -> color=000;
  - dominant count 10 with MIN_COUNT=16 -> 000;
  - dominant exceeding another by exactly MARGIN -> 000.
- Saturation: COUNT_W=4, GATE_CYCLES=200, period 4 -> count holds at 15 and does not wrap.
- Enable behaviour: enable low at start of blue GATE -> that round completes with one valid, then IDLE with filter=00. Re-enabling starts a fresh round at red.
